// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected classifier.
// Holds the FSM state encoding, default parameters and accumulator sizing.
package fc_pkg;

  localparam int FC_N_IN  = 64;
  localparam int FC_LANES = 4;
  localparam int FC_N_CLS = 4;
  localparam int FC_DW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } fc_state_e;

  // Full-precision product width plus growth for summing n_in terms.
  function automatic int acc_width(input int dw, input int n_in);
    return 2 * dw + $clog2(n_in);
  endfunction

endpackage

// File: rtl/fc_dot_lane.sv
// One class's LANES-wide signed dot product of a feature beat against its weights.
// Purely combinational; products are kept at full precision and sign-extended.
module fc_dot_lane #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 22
) (
  input  logic [LANES*DW-1:0]     x,
  input  logic [LANES*DW-1:0]     w,
  output logic signed [ACC_W-1:0] dot
);

  logic signed [2*DW-1:0] prod [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_mul
    assign prod[k] = $signed(x[k*DW +: DW]) * $signed(w[k*DW +: DW]);
  end

  always_comb begin
    dot = '0;
    for (int k = 0; k < LANES; k++) begin
      dot = dot + ACC_W'(prod[k]);
    end
  end

endmodule

// File: rtl/fc_classifier.sv
// Streaming fully-connected classifier: accumulates N_CLS dot products over
// N_IN/LANES input beats, then picks the highest-scoring class one per cycle.
module fc_classifier
  import fc_pkg::*;
#(
  parameter  int N_IN  = FC_N_IN,
  parameter  int LANES = FC_LANES,
  parameter  int N_CLS = FC_N_CLS,
  parameter  int DW    = FC_DW,
  localparam int CW    = $clog2(N_CLS),
  localparam int IW    = $clog2(N_IN),
  localparam int ACC_W = acc_width(DW, N_IN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  input  logic                w_we,
  input  logic [CW-1:0]       w_cls,
  input  logic [IW-1:0]       w_idx,
  input  logic [DW-1:0]       w_data,
  output logic                cls_valid,
  input  logic                cls_ready,
  output logic [CW-1:0]       cls_idx,
  output logic [ACC_W-1:0]    cls_score,
  output logic                busy
);

  localparam int BEATS = N_IN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  fc_state_e              state;
  logic [BW-1:0]          beat_cnt;
  logic [CW-1:0]          arg_cnt;
  logic signed [DW-1:0]   w_mem [N_CLS][N_IN];
  logic signed [ACC_W-1:0] acc  [N_CLS];
  logic signed [ACC_W-1:0] dot  [N_CLS];
  logic [CW-1:0]          best_idx;
  logic signed [ACC_W-1:0] best_score;
  logic                   accept;
  logic                   last_beat;
  logic                   w_ok;

  assign in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign busy      = (state != ST_IDLE);
  assign cls_idx   = best_idx;
  assign cls_score = best_score;

  // Weights are frozen from the first accepted beat until the result is taken,
  // including a write that lands on the same edge as that first beat.
  assign w_ok = w_we && (state == ST_IDLE) && !accept &&
                (int'(w_cls) < N_CLS) && (int'(w_idx) < N_IN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CLS; c++)
        for (int i = 0; i < N_IN; i++)
          w_mem[c][i] <= '0;
    end else if (w_ok) begin
      w_mem[w_cls][w_idx] <= w_data;
    end
  end

  for (genvar c = 0; c < N_CLS; c++) begin : g_cls
    logic [LANES*DW-1:0] wv;

    always_comb begin
      wv = '0;
      for (int k = 0; k < LANES; k++)
        wv[k*DW +: DW] = w_mem[c][IW'(int'(beat_cnt) * LANES + k)];
    end

    fc_dot_lane #(
      .LANES (LANES),
      .DW    (DW),
      .ACC_W (ACC_W)
    ) u_dot (
      .x   (in_data),
      .w   (wv),
      .dot (dot[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      arg_cnt    <= '0;
      best_idx   <= '0;
      best_score <= '0;
      cls_valid  <= 1'b0;
      for (int c = 0; c < N_CLS; c++) acc[c] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            for (int c = 0; c < N_CLS; c++) acc[c] <= acc[c] + dot[c];
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= ST_ARGMAX;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
              state    <= ST_ACCUM;
            end
          end
        end
        ST_ARGMAX: begin
          // Class 0 seeds the search; strict > keeps the lowest index on ties.
          if (arg_cnt == '0 || acc[arg_cnt] > best_score) begin
            best_idx   <= arg_cnt;
            best_score <= acc[arg_cnt];
          end
          if (arg_cnt == CW'(N_CLS - 1)) begin
            arg_cnt   <= '0;
            cls_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            arg_cnt <= arg_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (cls_ready) begin
            for (int c = 0; c < N_CLS; c++) acc[c] <= '0;
            cls_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_classifier.sv
// Scoreboard bench for fc_classifier: driver pushes model results, monitor pops on handshake.
module tb_fc_classifier;

  localparam int N_IN  = 64;
  localparam int LANES = 4;
  localparam int N_CLS = 4;
  localparam int DW    = 8;
  localparam int CW    = $clog2(N_CLS);
  localparam int IW    = $clog2(N_IN);
  localparam int ACC_W = 2 * DW + $clog2(N_IN);
  localparam int BEATS = N_IN / LANES;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data = '0;
  logic                w_we = 1'b0;
  logic [CW-1:0]       w_cls = '0;
  logic [IW-1:0]       w_idx = '0;
  logic [DW-1:0]       w_data = '0;
  logic                cls_valid;
  logic                cls_ready = 1'b1;
  logic [CW-1:0]       cls_idx;
  logic [ACC_W-1:0]    cls_score;
  logic                busy;

  fc_classifier #(.N_IN(N_IN), .LANES(LANES), .N_CLS(N_CLS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_we(w_we), .w_cls(w_cls), .w_idx(w_idx), .w_data(w_data),
    .cls_valid(cls_valid), .cls_ready(cls_ready), .cls_idx(cls_idx),
    .cls_score(cls_score), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int score; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   wm   [N_CLS][N_IN];
  int   feat [N_IN];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_e = 0;
  logic drv_last = 1'b0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Edge bookkeeping: cyc after edge E reads E; last_e marks the last-beat edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready && drv_last) last_e <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (cls_valid && !prev_valid) chk("latency", cyc - last_e, N_CLS);
      if (cls_valid && cls_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got idx %0d, expected no result", cls_idx);
        end else begin
          mon_e = sbq.pop_front();
          chk("cls_idx", int'(cls_idx), mon_e.idx);
          chk("cls_score", int'($signed(cls_score)), mon_e.score);
        end
      end
    end
    prev_valid <= cls_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cls_valid"}, int'(cls_valid), 0);
    chk({tag, "_cls_idx"}, int'(cls_idx), 0);
    chk({tag, "_cls_score"}, int'($signed(cls_score)), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    w_we = 1'b0;
    drv_last = 1'b0;
    cls_ready = 1'b1;
    sbq.delete();
    for (int c = 0; c < N_CLS; c++)
      for (int i = 0; i < N_IN; i++) wm[c][i] = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wr(input int c, input int i, input int d);
    w_we = 1'b1;
    w_cls = CW'(c);
    w_idx = IW'(i);
    w_data = DW'(d);
    tick();
    w_we = 1'b0;
    wm[c][i] = d;
  endtask

  // mode 0 zero, 1 class2 all ones, 2 class3 all -128, 3 random, 4 tie on classes 1 and 3
  task automatic load_w(input int mode);
    int d;
    for (int c = 0; c < N_CLS; c++)
      for (int i = 0; i < N_IN; i++) begin
        case (mode)
          1:       d = (c == 2) ? 1 : 0;
          2:       d = (c == 3) ? -128 : 0;
          3:       d = int'($urandom_range(255)) - 128;
          4:       d = (c == 1 || c == 3) ? 1 : 0;
          default: d = 0;
        endcase
        wr(c, i, d);
      end
  endtask

  task automatic rand_feat();
    for (int i = 0; i < N_IN; i++) feat[i] = int'($urandom_range(255)) - 128;
  endtask

  task automatic const_feat(input int v);
    for (int i = 0; i < N_IN; i++) feat[i] = v;
  endtask

  // Issues nb beats; a full inference pushes the model's expected winner.
  task automatic run(input int nb, input bit gap, input bit wr_first, input bit wr_mid);
    int s [N_CLS];
    int best;
    int t;
    exp_t e;
    for (int c = 0; c < N_CLS; c++) begin
      s[c] = 0;
      for (int i = 0; i < N_IN; i++) s[c] += feat[i] * wm[c][i];
    end
    best = 0;
    for (int c = 1; c < N_CLS; c++) if (s[c] > s[best]) best = c;
    e.idx = best;
    e.score = s[best];
    if (nb == BEATS) sbq.push_back(e);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < LANES; k++) in_data[k*DW +: DW] = DW'(feat[b*LANES+k]);
      in_valid = 1'b1;
      drv_last = (b == BEATS - 1);
      if ((wr_first && b == 0) || (wr_mid && b == BEATS / 2)) begin
        w_we = 1'b1;
        w_cls = CW'(best);
        w_idx = IW'(wr_first && b == 0 ? 0 : N_IN - 1);
        w_data = (wm[best][int'(w_idx)] >= 0) ? DW'(-128) : DW'(127);
      end
      t = 0;
      while (!in_ready && t < 100) begin tick(); t++; end
      if (t >= 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_accept_timeout: in_ready %0d, expected 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      drv_last = 1'b0;
      w_we = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_result();
    int t = 0;
    while (sbq.size() != 0 && t < 200) begin tick(); t++; end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL result_timeout: %0d pending, expected 0", sbq.size());
      sbq.delete();
    end
    tick();
  endtask

  task automatic hold_test();
    int t = 0;
    cls_ready = 1'b0;
    load_w(3);
    rand_feat();
    run(BEATS, 1'b0, 1'b0, 1'b0);
    while (!cls_valid && t < 100) begin tick(); t++; end
    chk("hold_reached_done", int'(cls_valid), 1);
    for (int n = 0; n < 5; n++) begin
      chk("hold_valid", int'(cls_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_busy", int'(busy), 1);
      if (sbq.size() != 0) begin
        chk("hold_idx", int'(cls_idx), sbq[0].idx);
        chk("hold_score", int'($signed(cls_score)), sbq[0].score);
      end
      tick();
    end
    cls_ready = 1'b1;
    tick();
    chk("release_busy", int'(busy), 0);
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_valid", int'(cls_valid), 0);
    wait_result();
  endtask

  initial begin
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(cls_valid), 0);
    do_reset();
    check_reset_state("reset");

    // all-zero weights: tie everywhere resolves to class 0
    const_feat(1);
    run(BEATS, 1'b0, 1'b0, 1'b0);
    wait_result();

    load_w(1);
    run(BEATS, 1'b0, 1'b0, 1'b0);
    wait_result();

    load_w(2);
    const_feat(-128);
    run(BEATS, 1'b0, 1'b0, 1'b0);
    wait_result();

    load_w(4);
    const_feat(1);
    run(BEATS, 1'b0, 1'b0, 1'b0);
    wait_result();

    hold_test();
    // the run right after release starts from cleared accumulators
    rand_feat();
    run(BEATS, 1'b0, 1'b0, 1'b0);
    wait_result();
    run(BEATS, 1'b1, 1'b0, 1'b0);
    wait_result();

    // partial run aborted by reset, then a clean run with ignored writes
    load_w(1);
    const_feat(1);
    run(8, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_reset_state("midrun_reset");
    load_w(1);
    run(BEATS, 1'b0, 1'b0, 1'b1);
    wait_result();
    run(BEATS, 1'b1, 1'b1, 1'b0);
    wait_result();

    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) load_w(3);
      rand_feat();
      run(BEATS, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      wait_result();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
